// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the controller state encoding, the default operand width and
// the matching iteration counter width.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIV_WIDTH = 16;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/divider_step.sv
// One restoring division iteration: shift partial remainder left by one
// quotient bit, trial-subtract the divisor, shift the result bit into Q.
// Ports: r/q/d in -> r_next/q_next out; purely combinational, no latency.
module divider_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] r,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] r_next,
   output logic [WIDTH-1:0] q_next
);

   // The partial remainder is always below D, so it fits in WIDTH bits;
   // only the shifted trial value needs the extra bit.
   logic [WIDTH:0] t;
   logic [WIDTH:0] diff;
   logic           ge;

   always_comb begin
      t    = {r, q[WIDTH-1]};
      diff = t - {1'b0, d};
      ge   = (t >= {1'b0, d});
      if (ge) begin
         r_next = diff[WIDTH-1:0];
         q_next = {q[WIDTH-2:0], 1'b1};
      end else begin
         r_next = t[WIDTH-1:0];
         q_next = {q[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_divider_restoring.sv
// Iterative restoring divider, 2*WIDTH / WIDTH -> WIDTH quotient + remainder.
// Latency: WIDTH+1 cycles from accept to out_valid (1 cycle for div-by-zero/overflow).
// Backpressure: result and flags held in DONE until out_ready; one op in flight.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready + dividend/divisor;
//        out_valid/out_ready + quotient/remainder/div_by_zero/overflow.
// Optional: define DIVIDER_SIGNED_EN to add in_signed (two's complement operands).
module seq_divider_restoring
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
`ifdef DIVIDER_SIGNED_EN
   input  logic                 in_signed,
`endif
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 div_by_zero,
   output logic                 overflow
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] r, q, d;
   logic [CNT_W-1:0] count;
   logic             dbz, ovf;
   logic [WIDTH-1:0] r_step, q_step;
   logic [WIDTH-1:0] r_fix, q_fix;
   logic             sgn_ovf;

   logic [2*WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0]   dvs_mag;
   logic               pre_ovf;
   logic               accept;
   logic               last_iter;

`ifdef DIVIDER_SIGNED_EN
   logic is_signed, q_neg, r_neg;
`endif

   // Operand magnitudes; in unsigned mode these are the raw operands.
   always_comb begin
      dvd_mag = dividend;
      dvs_mag = divisor;
`ifdef DIVIDER_SIGNED_EN
      if (in_signed) begin
         dvd_mag = dividend[2*WIDTH-1] ? -dividend : dividend;
         dvs_mag = divisor[WIDTH-1]    ? -divisor  : divisor;
      end
`endif
   end

   // Upper half >= divisor means the quotient needs more than WIDTH bits.
   assign pre_ovf   = (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag);
   assign accept    = in_valid && in_ready;
   assign last_iter = (count == CNT_W'(WIDTH - 1));

   divider_step #(.WIDTH(WIDTH)) u_step (
      .r      (r),
      .q      (q),
      .d      (d),
      .r_next (r_step),
      .q_next (q_step)
   );

   // Sign correction folded into the final iteration so latency is unchanged.
   always_comb begin
      q_fix   = q_step;
      r_fix   = r_step;
      sgn_ovf = 1'b0;
`ifdef DIVIDER_SIGNED_EN
      if (q_neg) q_fix = -q_step;
      if (r_neg) r_fix = -r_step;
      if (is_signed) begin
         // Negative results may reach -2^(W-1); positive ones stop at 2^(W-1)-1.
         sgn_ovf = q_neg ? (q_step > {1'b1, {(WIDTH-1){1'b0}}}) : q_step[WIDTH-1];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = ((divisor == '0) || pre_ovf) ? DONE : CALC;
            end
         end
         CALC: begin
            if (last_iter) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r     <= '0;
         q     <= '0;
         d     <= '0;
         count <= '0;
         dbz   <= 1'b0;
         ovf   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         is_signed <= 1'b0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
`endif
      end else begin
         if (accept) begin
            count <= '0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            is_signed <= in_signed;
            q_neg     <= in_signed && (dividend[2*WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg     <= in_signed && dividend[2*WIDTH-1];
`endif
            if (divisor == '0) begin
               dbz <= 1'b1;
               q   <= '1;
               r   <= dividend[WIDTH-1:0];
            end else if (pre_ovf) begin
               ovf <= 1'b1;
               q   <= '1;
               r   <= dividend[WIDTH-1:0];
            end else begin
               r <= dvd_mag[2*WIDTH-1:WIDTH];
               q <= dvd_mag[WIDTH-1:0];
               d <= dvs_mag;
            end
         end else if (state == CALC) begin
            count <= count + 1'b1;
            if (last_iter) begin
               q   <= q_fix;
               r   <= r_fix;
               ovf <= sgn_ovf;
            end else begin
               q <= q_step;
               r <= r_step;
            end
         end
      end
   end

   assign quotient    = q;
   assign remainder   = r;
   assign div_by_zero = dbz;
   assign overflow    = ovf;

endmodule

// File: doc/seq_divider_restoring.md
Name: seq_divider_restoring

Overview:
- Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor -> WIDTH-bit quotient and WIDTH-bit remainder.
- Inverse companion of the combinational 16x16 multiplier datapath; divides a 32-bit product back by a 16-bit operand.
- One quotient bit per clock; valid/ready handshake on both input and output.

Parameters:
- WIDTH, 16, divisor/quotient/remainder width; dividend is 2*WIDTH bits.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  2*WIDTH  numerator
- divisor  input  WIDTH  denominator
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  quotient
- remainder  output  WIDTH  remainder
- div_by_zero  output  1  divisor was 0
- overflow  output  1  quotient does not fit in WIDTH bits

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, iteration counter=0.
- States:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready.
    - divisor==0 -> DONE; div_by_zero=1, quotient={WIDTH{1}}, remainder=dividend[WIDTH-1:0].
    - Else dividend[2W-1:W] >= divisor -> DONE; overflow=1, same quotient/remainder fill.
    - Else -> CALC; load R=dividend[2W-1:W] (W+1 bits), Q=dividend[W-1:0], D=divisor, count=0.
  - CALC: in_ready=0. Each cycle: T={R[W-1:0],Q[W-1]}; if T>=D then R=T-D, Q={Q[W-2:0],1}; else R=T, Q={Q[W-2:0],0}; count++. After WIDTH iterations -> DONE.
  - DONE: out_valid=1; quotient=Q, remainder=R[W-1:0]. Outputs and flags held stable until out_valid&&out_ready, then -> IDLE with out_valid=0.
- Latency:
  - Normal: accept edge at cycle t; out_valid high from cycle t+WIDTH+1 (16 CALC cycles for WIDTH=16).
  - Error cases: out_valid high from cycle t+1.
- Throughput: one operation in flight. No new accept in DONE, even if out_ready is high in the same cycle; the next accept occurs in IDLE.
- Invariant: R < D at every CALC step; the subtract fits in W+1 bits.
- Flags: cleared on every new accept; div_by_zero has priority over overflow.
- Input hold: operands are sampled only at accept; changes while busy are ignored.
- Reset mid-operation: rst_n low at any edge aborts CALC/DONE and returns to reset values; the pending result is lost.
- Stability: outputs and flags are unchanged while out_valid=1 and out_ready=0 (backpressure).

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined:
  - Extra input in_signed (1 bit, sampled at accept). When 1, operands are two's complement.
  - Magnitudes are divided unsigned. Quotient is negated if the operand signs differ (truncation toward zero). Remainder takes the dividend's sign.
  - overflow=1 if the signed quotient is outside [-2^(W-1), 2^(W-1)-1]; checked at DONE entry.
  - Sign fix is applied on the CALC->DONE transition; latency unchanged.
- Undefined: port absent; unsigned only.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, DONE}
  - DIV_WIDTH=16
  - counter width $clog2(DIV_WIDTH+1)
- Sub-module divider_step: combinational single restoring iteration (R, Q, D -> R', Q'), instantiated once in CALC.

Test Plan:
- 100 / 7 -> quotient=14, remainder=2, out_valid exactly 17 cycles after accept (accept edge + 16 CALC cycles).
- 0xFFFE0001 / 0xFFFF -> quotient=0xFFFF, remainder=0 (round-trips the multiplier's maximum product).
- 0x1234 / 0 -> div_by_zero=1, quotient=0xFFFF, remainder=0x1234, out_valid 1 cycle after accept.
- 0x00010000 / 1 -> overflow=1, div_by_zero=0; next op 9 / 3 -> quotient=3, remainder=0, flags cleared.
- Backpressure and reset:
  - out_ready low 5 cycles in DONE -> outputs and flags stable, in_ready=0.
  - rst_n low at CALC cycle 8 -> next cycle IDLE, out_valid=0, in_ready=1.
- DIVIDER_SIGNED_EN, in_signed=1: -100 / 7 -> quotient=0xFFF2, remainder=0xFFFE; 0x80000000 / 0xFFFF -> overflow=1.
